shift_stage: RTL and testbench

Registered, handshaked shift execution stage for the CS 141 ALU datapath. Accepts shift operations from the decode/issue logic through a 2-entry input queue and drives the combinational 32-bit barrel shifter built from per-bit left-shift mux slices. Registers the shifter result and flags for the downstream writeback/result mux. Provides valid/ready flow control in both directions and a completed-operation counter.

---
 rtl/alu_pkg.sv | 17 +
 rtl/barrel_shift_32.sv | 69 ++++++
 rtl/shift_stage.sv | 123 ++++++++++++
 tb/tb_shift_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared shift-unit definitions: op encodings and the queued request bundle.
package alu_pkg;

    localparam int SHAMT_BITS = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] shamt;
    } shift_req_t;

endpackage

// File: rtl/barrel_shift_32.sv
// 32-bit combinational shifter built around one left-shift mux-slice ladder.
// Sign-fill SRA is compiled only with `SHIFT_SRA_EN defined.
module barrel_shift_32
    import alu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] data,
    input  logic [31:0] shamt,
    output logic [31:0] result,
    output logic        sat
);

    function automatic logic [31:0] sll_slices(
        input logic [31:0]           x,
        input logic [SHAMT_BITS-1:0] k
    );
        logic [31:0] s;
        s = x;
        for (int i = 0; i < SHAMT_BITS; i++) begin
            s = k[i] ? (s << (2 ** i)) : s;
        end
        return s;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) begin
            r[b] = x[31-b];
        end
        return r;
    endfunction

    logic [SHAMT_BITS-1:0] k;
    logic                  ovf;
    logic [31:0]           sll_v;
    logic [31:0]           srl_v;
    logic [31:0]           rol_v;

    assign k     = shamt[SHAMT_BITS-1:0];
    assign ovf   = |shamt[31:SHAMT_BITS];
    assign sat   = ovf;
    assign sll_v = sll_slices(data, k);
    assign srl_v = rev32(sll_slices(rev32(data), k));
    // k == 0 makes both halves equal to data, so no special case is needed
    assign rol_v = sll_v | rev32(sll_slices(rev32(data), -k));

`ifdef SHIFT_SRA_EN
    logic [31:0] sra_v;
    logic [31:0] fill_v;

    assign fill_v = {32{data[31]}};
    assign sra_v  = data[31] ? ~rev32(sll_slices(rev32(~data), k)) : srl_v;
`endif

    always_comb begin
        result = sll_v;
        unique case (op)
            OP_SLL: result = ovf ? '0 : sll_v;
`ifdef SHIFT_SRA_EN
            OP_SRL: result = ovf ? '0 : srl_v;
            OP_SRA: result = ovf ? fill_v : sra_v;
`else
            OP_SRL, OP_SRA: result = ovf ? '0 : srl_v;
`endif
            OP_ROL: result = rol_v;
        endcase
    end

endmodule

// File: rtl/shift_stage.sv
// Handshaked shift execute stage: input queue, barrel shifter, result register.
// `SHIFT_SRA_EN selects true arithmetic right shift for op 10.
module shift_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [N-1:0] in_data,
    input  logic [31:0]  in_shamt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_zero,
    output logic         out_sat,
    output logic [15:0]  op_count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    shift_req_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] used_q, used_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  result_q, result_d;
    logic          zero_q, zero_d;
    logic          sat_q, sat_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          push;
    logic          pop;
    logic          drain;
    shift_req_t    head;
    shift_req_t    wr_req;
    logic [31:0]   sh_result;
    logic          sh_sat;

    // in_ready comes only from the occupancy register
    assign in_ready = (used_q != FULL);
    assign push     = in_valid && in_ready;
    assign drain    = valid_q && out_ready;
    assign pop      = (used_q != '0) && (!valid_q || out_ready);
    assign head     = mem_q[rd_ptr_q];
    assign wr_req   = '{op: in_op, data: in_data, shamt: in_shamt};

    barrel_shift_32 u_shift (
        .op     (head.op),
        .data   (head.data),
        .shamt  (head.shamt),
        .result (sh_result),
        .sat    (sh_sat)
    );

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        used_d   = used_q;
        if (push && !pop) begin
            used_d = used_q + CW'(1);
        end else if (pop && !push) begin
            used_d = used_q - CW'(1);
        end
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        sat_d    = sat_q;
        cnt_d    = drain ? cnt_q + 16'd1 : cnt_q;
        if (pop) begin
            valid_d  = 1'b1;
            result_d = sh_result;
            zero_d   = (sh_result == '0);
            sat_d    = sh_sat;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= wr_req;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_sat    = sat_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_shift_stage.sv
// Directed and streaming checks for shift_stage.
// Expectations follow `SHIFT_SRA_EN when it is defined.
module tb_shift_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [31:0] in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_sat;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    shift_stage #(.N(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_sat    (out_sat),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] d,
                                          input logic [31:0] sh);
        logic       big;
        logic [4:0] k;
        big = (sh > 32'd31);
        k   = sh[4:0];
        case (op)
            2'b00: return big ? 32'h0 : d << k;
            2'b01: return big ? 32'h0 : d >> k;
`ifdef SHIFT_SRA_EN
            2'b10: return big ? {32{d[31]}} : 32'($signed(d) >>> k);
`else
            2'b10: return big ? 32'h0 : d >> k;
`endif
            default: return (d << k) | (d >> (6'd32 - {1'b0, k}));
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run1(input string tag, input logic [1:0] op,
                        input logic [31:0] d, input logic [31:0] sh,
                        input logic [31:0] er, input logic ez,
                        input logic es);
        in_op = op;
        in_data = d;
        in_shamt = sh;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, out_result, er);
        chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
        @(negedge clk);
        exp_cnt++;
        chk({tag, "_done"}, 32'(out_valid), 32'd0);
        chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int sent;
        int rcv;
        int bubbles;
        int cyc;
        bit have;
        bit started;
        logic [1:0]  r_op;
        logic [31:0] r_d;
        logic [31:0] r_sh;
        logic [31:0] e;
        logic [31:0] expq[$];

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 2'b00;
        in_data = '0;
        in_shamt = '0;
        out_ready = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'h0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_sat", 32'(out_sat), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);

        run1("sll4", 2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 0, 0);
        run1("sll32", 2'b00, 32'hFFFF_FFFF, 32'd32, 32'h0, 1, 1);
`ifdef SHIFT_SRA_EN
        run1("sra40", 2'b10, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 0, 1);
        run1("sra4", 2'b10, 32'hF000_0000, 32'd4, 32'hFF00_0000, 0, 0);
`else
        run1("sra40", 2'b10, 32'h8000_0000, 32'd40, 32'h0, 1, 1);
        run1("sra4", 2'b10, 32'hF000_0000, 32'd4, 32'h0F00_0000, 0, 0);
`endif
        run1("sra33p", 2'b10, 32'h7FFF_FFFF, 32'd33, 32'h0, 1, 1);
        run1("rol33", 2'b11, 32'h8000_0001, 32'd33, 32'h0000_0003, 0, 1);
        run1("rol0", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 0, 0);
        run1("rol4", 2'b11, 32'h1234_5678, 32'd4, 32'h2345_6781, 0, 0);
        run1("srl31", 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 0, 0);
        run1("srl1z", 2'b01, 32'h0000_0001, 32'd1, 32'h0, 1, 0);
        run1("sll31", 2'b00, 32'h0000_00A5, 32'd31, 32'h8000_0000, 0, 0);
        run1("srlbig", 2'b01, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1, 1);

        // backpressure: 4 offered, 3 accepted
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_op = 2'b00;
            in_data = 32'h1;
            in_shamt = 32'(i + 1);
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", out_result, 32'h2);
        @(negedge clk);
        chk("bp_hold", out_result, 32'h2);
        chk("bp_hold_cnt", 32'(op_count), 32'(exp_cnt));
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain1", out_result, 32'h4);
        chk("bp_drain1_v", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_drain2", out_result, 32'h8);
        chk("bp_drain2_v", 32'(out_valid), 32'd1);
        @(negedge clk);
        exp_cnt += 3;
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_cnt", 32'(op_count), 32'(exp_cnt));

        // streaming with simultaneous push and pop
        do_reset();
        out_ready = 1'b1;
        sent = 0;
        rcv = 0;
        bubbles = 0;
        cyc = 0;
        have = 0;
        started = 0;
        r_op = '0;
        r_d = '0;
        r_sh = '0;
        while (rcv < 1000 && cyc < 5000) begin
            if (out_valid) begin
                e = (expq.size() != 0) ? expq.pop_front() : ~out_result;
                chk("stream", out_result, e);
                rcv++;
                started = 1;
            end else if (started) begin
                bubbles++;
            end
            if (!have && sent < 1000) begin
                r_op = 2'($urandom_range(0, 3));
                r_d = $urandom;
                r_sh = ($urandom_range(0, 3) == 0) ? $urandom
                                                   : $urandom_range(0, 40);
                have = 1;
            end
            if (have) begin
                in_op = r_op;
                in_data = r_d;
                in_shamt = r_sh;
                in_valid = 1'b1;
                if (in_ready) begin
                    expq.push_back(model(r_op, r_d, r_sh));
                    sent++;
                    have = 0;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_rcv", 32'(rcv), 32'd1000);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_cnt", 32'(op_count), 32'd1000);

        // reset with a held result and two queued ops
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_op = 2'b00;
            in_data = 32'h5;
            in_shamt = 32'(i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
        chk("mid_cnt", 32'(op_count), 32'd0);
        out_ready = 1'b1;
        exp_cnt = 0;
        run1("post_rst", 2'b00, 32'h3, 32'd1, 32'h6, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
